// File: rtl/pe_ws_dbuf_if.sv
// Bundle of the pe_ws_dbuf data, weight and control signals.
// Beats use valid-only semantics: a beat is taken every cycle act_valid_in is high, with no backpressure.
interface pe_ws_dbuf_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 16
);
    logic              weight_load;
    logic              weight_swap;
    logic [DATA_W-1:0] weight_in;
    logic              act_valid_in;
    logic              act_last_in;
    logic [DATA_W-1:0] activation_in;
    logic [ACC_W-1:0]  partial_sum_in;
    logic              mode;
    logic              acc_clear;
    logic [DATA_W-1:0] reg_activation;
    logic              act_valid_out;
    logic [DATA_W-1:0] reg_weight;
    logic [ACC_W-1:0]  reg_partial_sum;
    logic              psum_valid_out;
    logic              sat_flag;

    modport master (
        output weight_load, weight_swap, weight_in, act_valid_in, act_last_in,
               activation_in, partial_sum_in, mode, acc_clear,
        input  reg_activation, act_valid_out, reg_weight, reg_partial_sum,
               psum_valid_out, sat_flag
    );

    modport slave (
        input  weight_load, weight_swap, weight_in, act_valid_in, act_last_in,
               activation_in, partial_sum_in, mode, acc_clear,
        output reg_activation, act_valid_out, reg_weight, reg_partial_sum,
               psum_valid_out, sat_flag
    );
endinterface

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary PE with shadow/active weights, 1- or 2-stage MAC and local accumulate mode.
// Define PE_SAT_EN to clamp overflowed results instead of wrapping them.
module pe_ws_dbuf #(
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 10,
    parameter int ACC_W    = 16,
    parameter int MUL_PIPE = 1
) (
    input logic         clk,
    input logic         rst,
    pe_ws_dbuf_if.slave bus
);
    localparam int PROD_W = 2 * DATA_W + 2;
    localparam int SUM_W  = PROD_W - FRAC_W;

    logic [DATA_W-1:0] r_act;
    logic              r_act_valid;
    logic [DATA_W-1:0] r_w_shadow;
    logic [DATA_W-1:0] r_w_active;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  r_psum;
    logic              r_psum_valid;
    logic              r_sat;

    // Two guard bits on the product keep the shifted value exact at SUM_W.
    logic signed [PROD_W-1:0] w_prod;
    logic [SUM_W-1:0]         w_scaled_in;
    logic                     w_unused_frac;

    assign w_prod        = $signed(bus.activation_in) * $signed(r_w_active);
    assign w_scaled_in   = w_prod[PROD_W-1:FRAC_W];
    assign w_unused_frac = ^w_prod[FRAC_W-1:0];

    logic             b_valid;
    logic             b_mode;
    logic             b_last;
    logic             b_clear;
    logic [SUM_W-1:0] b_scaled;
    logic [ACC_W-1:0] b_psum;

    generate
        if (MUL_PIPE == 2) begin : g_pipe2
            logic             r_a_valid;
            logic             r_a_mode;
            logic             r_a_last;
            logic             r_a_clear;
            logic [SUM_W-1:0] r_a_scaled;
            logic [ACC_W-1:0] r_a_psum;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a_valid  <= 1'b0;
                    r_a_mode   <= 1'b0;
                    r_a_last   <= 1'b0;
                    r_a_clear  <= 1'b0;
                    r_a_scaled <= '0;
                    r_a_psum   <= '0;
                end else begin
                    r_a_valid  <= bus.act_valid_in;
                    r_a_mode   <= bus.mode;
                    r_a_last   <= bus.act_last_in;
                    r_a_clear  <= bus.acc_clear;
                    r_a_scaled <= w_scaled_in;
                    r_a_psum   <= bus.partial_sum_in;
                end
            end

            assign b_valid  = r_a_valid;
            assign b_mode   = r_a_mode;
            assign b_last   = r_a_last;
            assign b_clear  = r_a_clear;
            assign b_scaled = r_a_scaled;
            assign b_psum   = r_a_psum;
        end else begin : g_pipe1
            assign b_valid  = bus.act_valid_in;
            assign b_mode   = bus.mode;
            assign b_last   = bus.act_last_in;
            assign b_clear  = bus.acc_clear;
            assign b_scaled = w_scaled_in;
            assign b_psum   = bus.partial_sum_in;
        end
    endgenerate

    logic [SUM_W-1:0] w_addend;
    logic [SUM_W-1:0] w_sum;
    logic             w_ovf;
    logic [ACC_W-1:0] w_result;

    always_comb begin
        w_addend = '0;
        if (b_mode) begin
            if (!b_clear) begin
                w_addend = {{(SUM_W-ACC_W){r_acc[ACC_W-1]}}, r_acc};
            end
        end else begin
            w_addend = {{(SUM_W-ACC_W){b_psum[ACC_W-1]}}, b_psum};
        end
    end

    assign w_sum = b_scaled + w_addend;

    // In range exactly when every bit from ACC_W-1 upward matches the sign.
    assign w_ovf = (|w_sum[SUM_W-1:ACC_W-1]) && !(&w_sum[SUM_W-1:ACC_W-1]);

`ifdef PE_SAT_EN
    always_comb begin
        w_result = w_sum[ACC_W-1:0];
        if (w_ovf) begin
            w_result = w_sum[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign w_result = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_act        <= '0;
            r_act_valid  <= 1'b0;
            r_w_shadow   <= '0;
            r_w_active   <= '0;
            r_acc        <= '0;
            r_psum       <= '0;
            r_psum_valid <= 1'b0;
            r_sat        <= 1'b0;
        end else begin
            r_act_valid <= bus.act_valid_in;
            if (bus.act_valid_in) begin
                r_act <= bus.activation_in;
            end
            // Swap reads the pre-load shadow, so load+swap promotes the old value.
            if (bus.weight_swap) begin
                r_w_active <= r_w_shadow;
            end
            if (bus.weight_load) begin
                r_w_shadow <= bus.weight_in;
            end
            r_psum_valid <= 1'b0;
            if (b_valid) begin
                r_psum <= w_result;
                if (w_ovf) begin
                    r_sat <= 1'b1;
                end
                if (b_mode) begin
                    r_acc        <= w_result;
                    r_psum_valid <= b_last;
                end else begin
                    r_psum_valid <= 1'b1;
                end
            end else if (b_mode && b_clear) begin
                r_acc <= '0;
            end
        end
    end

    assign bus.reg_activation  = r_act;
    assign bus.act_valid_out   = r_act_valid;
    assign bus.reg_weight      = r_w_shadow;
    assign bus.reg_partial_sum = r_psum;
    assign bus.psum_valid_out  = r_psum_valid;
    assign bus.sat_flag        = r_sat;
endmodule

// File: doc/pe_ws_dbuf.md
Name: pe_ws_dbuf

Overview:
- Parametrised, weight-stationary systolic-array processing element; successor to the fixed 16-bit PE.
- Adds configurable data, fraction and accumulator widths, and a double-buffered weight (shadow plus active), so the next weight set shifts in while the current one computes.
- Adds a multiply pipeline of 1 or 2 stages with valid tracking, and a local-accumulate (output-stationary) mode.
- Tiles in a 2-D array: activations pass east, weights shift south through the shadow chain, partial sums pass south.

Parameters:
- DATA_W, 16: activation/weight width, signed two's complement.
- FRAC_W, 10: fractional bits; product scaled by arithmetic right shift of FRAC_W.
- ACC_W, 16: partial-sum/accumulator width, ACC_W >= DATA_W.
- MUL_PIPE, 1: multiply/add pipeline depth; legal values 1 or 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- weight_load  in  1  capture weight_in into the shadow weight.
- weight_swap  in  1  copy shadow weight into the active weight.
- weight_in  in  DATA_W  weight from north neighbour or loader.
- act_valid_in  in  1  activation beat valid.
- act_last_in  in  1  last beat of an accumulation (mode 1 only).
- activation_in  in  DATA_W  activation from west.
- partial_sum_in  in  ACC_W  partial sum from north, aligned with activation_in.
- mode  in  1  0 = systolic pass-through sum, 1 = local accumulate.
- acc_clear  in  1  restart accumulator (mode 1).
- reg_activation  out  DATA_W  registered activation to east.
- act_valid_out  out  1  registered act_valid_in.
- reg_weight  out  DATA_W  shadow weight to south (weight chain).
- reg_partial_sum  out  ACC_W  result / partial sum to south.
- psum_valid_out  out  1  reg_partial_sum valid.
- sat_flag  out  1  sticky overflow indicator.

Behaviour:
- Reset:
  - rst sampled at posedge clk.
  - Every register cleared, including shadow weight, active weight, accumulator and pipeline valids.
  - All outputs 0 the cycle after rst is high.
  - rst mid-operation discards all in-flight beats; no psum_valid_out is produced for them.
- Activation path:
  - reg_activation loads activation_in only when act_valid_in = 1; otherwise it holds.
  - act_valid_out equals act_valid_in delayed by exactly 1 cycle, independent of MUL_PIPE.
- Weights:
  - weight_load: shadow weight <= weight_in. reg_weight = shadow weight, so the shift-chain latency is 1 cycle per PE.
  - weight_swap: active weight <= shadow weight.
  - load and swap in the same cycle: active weight takes the OLD shadow value; shadow takes weight_in.
  - A beat accepted in cycle t uses the active weight as registered at the start of t. A swap in cycle t therefore affects beats from t+1 onward.
- Arithmetic, per valid beat:
  - prod = activation_in * active weight, full 2*DATA_W signed.
  - scaled = prod >>> FRAC_W (arithmetic shift; rounds toward negative infinity).
  - sum = scaled + addend, computed exactly at 2*DATA_W-FRAC_W+2 bits.
  - addend = partial_sum_in in mode 0, accumulator in mode 1.
  - Overflow occurs when sum lies outside [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - On overflow: sat_flag is set; it stays set until rst. Result conversion depends on the optional feature.
- Pipeline:
  - mode, act_last_in and partial_sum_in are captured alongside the beat and travel with it.
  - Mode changes with beats in flight are legal; each beat uses the mode it entered with.
  - MUL_PIPE = 1: registers on the output only.
  - MUL_PIPE = 2: adds a product register; partial_sum_in is delayed internally to stay aligned.
- Mode 0:
  - reg_partial_sum = result, MUL_PIPE cycles after the input beat.
  - psum_valid_out = beat valid delayed by MUL_PIPE.
  - The accumulator is untouched.
- Mode 1:
  - Accumulator <= result on each valid beat.
  - acc_clear with a valid beat: accumulator <= scaled (fresh start, addend 0).
  - acc_clear without a valid beat: accumulator <= 0.
  - reg_partial_sum tracks the accumulator.
  - psum_valid_out pulses exactly 1 cycle, MUL_PIPE cycles after the beat carrying act_last_in.
  - acc_clear and act_last_in on the same beat: single-beat result, valid pulse asserted.
- No valid beat: reg_partial_sum holds its value; psum_valid_out = 0.

Optional Feature:
- Macro: PE_SAT_EN.
- Defined: overflowed results clamp to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
- Undefined: results wrap to the low ACC_W bits (two's complement).
- sat_flag is set identically in both builds.

Test Plan:
- Defaults, MUL_PIPE = 1, for all scenarios.
- Reset: drive random inputs, then hold rst 1 cycle -> every output 0 next cycle; sat_flag 0.
- Basic MAC, mode 0:
  - Stimulus: load+swap weight 0x0400, then act 0x0C00 with psum_in 0x0200.
  - Response: reg_partial_sum = 0x0E00 and psum_valid_out = 1, one cycle later.
- Double buffer:
  - Stimulus: active weight 0x0400, load 0x0800 while streaming act 0x0400; swap; act 0x0400 again.
  - Response: first result 0x0400, second 0x0800. reg_weight = 0x0800 the cycle after load.
- Truncation: weight 0xFFFF, act 0x0001, psum_in 0 -> 0xFFFF.
- Overflow:
  - Stimulus: weight 0x7FFF, act 0x7FFF, psum_in 0.
  - Response: with PE_SAT_EN, 0x7FFF; without, 0xFFC0. sat_flag = 1 in both, and it persists.
- Accumulate, mode 1:
  - Stimulus: weight 0x0400; acts 0x0400 (with acc_clear), 0x0800, 0x0C00 (with act_last_in).
  - Response: single psum_valid_out pulse with reg_partial_sum = 0x1800.
  - Repeat with rst asserted after the second beat -> no pulse, accumulator 0.
